// File: rtl/sim_controller.sv
// Run-control front end for physics_engine: button debounce, run/pause/step/reload FSM, per-frame update gating, motion LEDs.
// Latency: a press acts 1 cycle after debounce acceptance; engine_step trails frame_start by 1 cycle; engine_rst_n rises 1 cycle after LOAD exits.
// Backpressure: none; presses arriving in LOAD or not meaningful in the current state are dropped, never queued.
//
// Ports:
//   clock_162, rst_n                      clock and asynchronous active-low reset
//   btn_run, btn_step, btn_load           raw asynchronous buttons (run/pause toggle, single step, reload)
//   frame_start                           one-cycle pulse per video frame
//   cfg_locations, cfg_velos              initial conditions, captured in the first LOAD cycle
//   locations                             live engine locations, watched for motion
//   init_locations, init_velos            registered initial conditions to the engine
//   engine_rst_n, engine_step             registered engine reset and one-cycle update strobe
//   state                                 00 LOAD, 01 PAUSE, 10 RUN, 11 STEP
//   led                                   [SPRITES-1:0] sticky motion flags, [15] running
module sim_controller #(
  parameter int SPRITES     = 2,
  parameter int DIMENSIONS  = 2,
  parameter int WIDTH       = 32,
  parameter int DB_CYCLES   = 1_620_000,
  parameter int LOAD_CYCLES = 4
) (
  input  logic                                clock_162,
  input  logic                                rst_n,
  input  logic                                btn_run,
  input  logic                                btn_step,
  input  logic                                btn_load,
  input  logic                                frame_start,
  input  logic [SPRITES*DIMENSIONS*WIDTH-1:0] cfg_locations,
  input  logic [SPRITES*DIMENSIONS*WIDTH-1:0] cfg_velos,
  input  logic [SPRITES*DIMENSIONS*WIDTH-1:0] locations,
  output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_locations,
  output logic [SPRITES*DIMENSIONS*WIDTH-1:0] init_velos,
  output logic                                engine_rst_n,
  output logic                                engine_step,
  output logic [1:0]                          state,
  output logic [15:0]                         led
);

  localparam int VW  = SPRITES * DIMENSIONS * WIDTH;
  localparam int SW  = DIMENSIONS * WIDTH;
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [LCW-1:0] LC_LAST = LCW'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_PAUSE = 2'b01,
    ST_RUN   = 2'b10,
    ST_STEP  = 2'b11
  } state_t;

  // Button bit order everywhere: [0] run, [1] step, [2] load.
  logic [2:0]          btn_raw;
  logic [2:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]          acc_q, acc_d, press_q, press_d;
  logic [2:0][DBW-1:0] db_cnt_q, db_cnt_d;

  state_t              state_q, state_d;
  logic [LCW-1:0]      load_cnt_q, load_cnt_d;
  logic                eng_rst_n_q, eng_rst_n_d;
  logic                eng_step_q, eng_step_d;
  logic                run_led_q, run_led_d;
  logic [VW-1:0]       init_loc_q, init_loc_d, init_vel_q, init_vel_d;
  logic [VW-1:0]       loc_prev_q, loc_prev_d;
  logic [SPRITES-1:0]  moved, flags_q, flags_d;
  logic                p_run, p_step, p_load;

  assign btn_raw = {btn_load, btn_step, btn_run};

  // Debounce: the accepted level flips only after the synchronised level has
  // disagreed with it for DB_CYCLES consecutive cycles; any agreement restarts.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    acc_d    = acc_q;
    press_d  = '0;
    db_cnt_d = db_cnt_q;
    for (int b = 0; b < 3; b++) begin
      if (sync2_q[b] == acc_q[b]) begin
        db_cnt_d[b] = '0;
      end else if (db_cnt_q[b] == DB_LAST) begin
        acc_d[b]    = ~acc_q[b];
        press_d[b]  = ~acc_q[b];
        db_cnt_d[b] = '0;
      end else begin
        db_cnt_d[b] = db_cnt_q[b] + DBW'(1);
      end
    end
  end

  assign p_run  = press_q[0];
  assign p_step = press_q[1];
  assign p_load = press_q[2];

  // Run-control FSM. Priority load > run > step falls out of the if-chains.
  // The strobe is only raised when the FSM stays in RUN/STEP, so it is never
  // visible in LOAD or PAUSE; STEP leaves for PAUSE during its strobe cycle.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    eng_step_d = 1'b0;
    init_loc_d = init_loc_q;
    init_vel_d = init_vel_q;
    case (state_q)
      ST_LOAD: begin
        if (load_cnt_q == '0) begin
          init_loc_d = cfg_locations;
          init_vel_d = cfg_velos;
        end
        if (load_cnt_q == LC_LAST) begin
          state_d    = ST_PAUSE;
          load_cnt_d = '0;
        end else begin
          load_cnt_d = load_cnt_q + LCW'(1);
        end
      end
      ST_PAUSE: begin
        if (p_load)      state_d = ST_LOAD;
        else if (p_run)  state_d = ST_RUN;
        else if (p_step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (p_load)     state_d = ST_LOAD;
        else if (p_run) state_d = ST_PAUSE;
        else            eng_step_d = frame_start;
      end
      ST_STEP: begin
        if (p_load)          state_d = ST_LOAD;
        else if (eng_step_q) state_d = ST_PAUSE;
        else                 eng_step_d = frame_start;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Motion monitor: flags only set once the engine is out of reset, and are
  // held clear for the whole LOAD period.
  always_comb begin
    moved = '0;
    for (int i = 0; i < SPRITES; i++) begin
      moved[i] = (locations[i*SW +: SW] != loc_prev_q[i*SW +: SW]);
    end
    loc_prev_d  = locations;
    eng_rst_n_d = (state_q != ST_LOAD);
    run_led_d   = (state_d == ST_RUN);
    if (state_q == ST_LOAD) flags_d = '0;
    else                    flags_d = flags_q | (moved & {SPRITES{eng_rst_n_q}});
  end

  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      acc_q       <= '0;
      press_q     <= '0;
      db_cnt_q    <= '0;
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      eng_rst_n_q <= 1'b0;
      eng_step_q  <= 1'b0;
      run_led_q   <= 1'b0;
      init_loc_q  <= '0;
      init_vel_q  <= '0;
      loc_prev_q  <= '0;
      flags_q     <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      acc_q       <= acc_d;
      press_q     <= press_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      eng_rst_n_q <= eng_rst_n_d;
      eng_step_q  <= eng_step_d;
      run_led_q   <= run_led_d;
      init_loc_q  <= init_loc_d;
      init_vel_q  <= init_vel_d;
      loc_prev_q  <= loc_prev_d;
      flags_q     <= flags_d;
    end
  end

  always_comb begin
    led                = '0;
    led[SPRITES-1:0]   = flags_q;
    led[15]            = run_led_q;
  end

  assign init_locations = init_loc_q;
  assign init_velos     = init_vel_q;
  assign engine_rst_n   = eng_rst_n_q;
  assign engine_step    = eng_step_q;
  assign state          = state_q;

endmodule

// File: tb/tb_sim_controller.sv
module tb_sim_controller;
  localparam int SPR = 2, DIM = 2, W = 32, DB = 8, LC = 4;
  localparam int VW = SPR * DIM * W, SW = DIM * W;
  localparam int S_LOAD = 0, S_PAUSE = 1, S_RUN = 2, S_STEP = 3;
  localparam logic [VW-1:0] CFG_LOC = {32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000};
  localparam logic [VW-1:0] CFG_VEL = {32'h0000_0010, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, btn_run, btn_step, btn_load, frame_start;
  logic [VW-1:0] cfg_locations, cfg_velos, locations, init_locations, init_velos;
  logic          engine_rst_n, engine_step;
  logic [1:0]    state;
  logic [15:0]   led;

  sim_controller #(.SPRITES(SPR), .DIMENSIONS(DIM), .WIDTH(W), .DB_CYCLES(DB), .LOAD_CYCLES(LC)) dut (
    .clock_162(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step), .btn_load(btn_load),
    .frame_start(frame_start), .cfg_locations(cfg_locations), .cfg_velos(cfg_velos),
    .locations(locations), .init_locations(init_locations), .init_velos(init_velos),
    .engine_rst_n(engine_rst_n), .engine_step(engine_step), .state(state), .led(led)
  );

  int checks = 0, errors = 0, n_steps = 0;

  // Reference model: values the outputs must show after the next clock edge.
  int            m_state, m_lcnt;
  bit            m_erst, m_step, m_run;
  bit [SPR-1:0]  m_flags;
  logic [VW-1:0] m_iloc, m_ivel, m_prev;
  bit            m_acc[3], m_press[3];
  bit            hist[3][$];   // raw button level seen at each clock edge

  task automatic chk(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit raw_btn(int b);
    case (b)
      0:       return btn_run;
      1:       return btn_step;
      default: return btn_load;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_LOAD; m_lcnt = 0; m_erst = 0; m_step = 0; m_run = 0;
    m_flags = '0; m_iloc = '0; m_ivel = '0; m_prev = '0;
    for (int b = 0; b < 3; b++) begin
      m_acc[b] = 0; m_press[b] = 0;
      hist[b].delete();
      repeat (DB + 2) hist[b].push_back(1'b0);
    end
  endtask

  task automatic model_edge();
    bit np[3], na[3], all_diff, nstep;
    int ns, nl, sz;
    bit [SPR-1:0] nflags;
    logic [VW-1:0] niloc, nivel;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // A button is accepted once its level, seen two edges late through the
    // synchroniser, has disagreed with the accepted level for DB edges running.
    for (int b = 0; b < 3; b++) begin
      sz = hist[b].size();
      all_diff = 1;
      for (int j = 1; j <= DB; j++) if (hist[b][sz-1-j] == m_acc[b]) all_diff = 0;
      na[b] = m_acc[b] ^ all_diff;
      np[b] = all_diff & ~m_acc[b];
      hist[b].push_back(raw_btn(b));
      if (hist[b].size() > DB + 2) void'(hist[b].pop_front());
    end
    ns = m_state; nl = 0; nstep = 0; niloc = m_iloc; nivel = m_ivel;
    case (m_state)
      S_LOAD: begin
        if (m_lcnt == 0) begin niloc = cfg_locations; nivel = cfg_velos; end
        if (m_lcnt == LC - 1) ns = S_PAUSE; else nl = m_lcnt + 1;
      end
      S_PAUSE: begin
        if (m_press[2]) ns = S_LOAD; else if (m_press[0]) ns = S_RUN; else if (m_press[1]) ns = S_STEP;
      end
      S_RUN: begin
        if (m_press[2]) ns = S_LOAD; else if (m_press[0]) ns = S_PAUSE;
        nstep = frame_start && (ns == S_RUN);
      end
      default: begin
        if (m_press[2]) ns = S_LOAD; else if (m_step) ns = S_PAUSE; else nstep = frame_start;
      end
    endcase
    nflags = m_flags;
    if (m_state == S_LOAD) nflags = '0;
    else for (int i = 0; i < SPR; i++)
      if (m_erst && (locations[i*SW +: SW] != m_prev[i*SW +: SW])) nflags[i] = 1'b1;
    m_erst  = (m_state != S_LOAD);
    m_run   = (ns == S_RUN);
    m_state = ns; m_lcnt = nl; m_step = nstep; m_flags = nflags;
    m_iloc = niloc; m_ivel = nivel; m_prev = locations;
    for (int b = 0; b < 3; b++) begin m_acc[b] = na[b]; m_press[b] = np[b]; end
  endtask

  task automatic compare_all();
    chk("state", state, m_state[1:0]);
    chk("engine_rst_n", engine_rst_n, m_erst);
    chk("engine_step", engine_step, m_step);
    chk("led", led, {m_run, 13'b0, m_flags});
    chk("init_locations", init_locations, m_iloc);
    chk("init_velos", init_velos, m_ivel);
    if (engine_step === 1'b1) n_steps++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic check_load_window(string tag);
    int n, e;
    n = 0;
    while (state == 2'd0 && n < 40) begin tick(); n++; end
    chk({tag, "_load_len"}, n, 4);
    e = n;
    while (engine_rst_n !== 1'b1 && e < 40) begin tick(); e++; end
    chk({tag, "_erst_rise"}, e, 5);
  endtask

  initial begin
    int s0, idx;
    rst_n = 1; btn_run = 0; btn_step = 0; btn_load = 0; frame_start = 0;
    locations = '0; cfg_locations = CFG_LOC; cfg_velos = CFG_VEL;
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    hold(2);
    rst_n = 1;
    check_load_window("boot");
    chk("boot_init_loc", init_locations, CFG_LOC);
    chk("boot_init_vel", init_velos, CFG_VEL);
    hold(2);

    // Bouncing run button, then a clean hold: one press only.
    for (int i = 0; i < 5; i++) begin btn_run = (i % 2 == 0); tick(); end
    hold(12);
    btn_run = 0;
    hold(12);
    chk("bounce_run_state", state, 2'd2);
    chk("bounce_run_led15", led[15], 1'b1);

    s0 = n_steps;
    for (int k = 0; k < 3; k++) begin frame_start = 1; tick(); frame_start = 0; hold(4); end
    chk("run_three_steps", n_steps - s0, 3);

    btn_run = 1; hold(12); btn_run = 0; hold(12);
    chk("pause_state", state, 2'd1);
    btn_step = 1; hold(12); btn_step = 0; hold(12);
    chk("step_wait_state", state, 2'd3);
    s0 = n_steps;
    for (int k = 0; k < 2; k++) begin frame_start = 1; tick(); frame_start = 0; hold(4); end
    chk("single_step_count", n_steps - s0, 1);
    chk("single_step_state", state, 2'd1);

    btn_run = 1; hold(12); btn_run = 0; hold(12);
    locations[SW +: W] = 32'hCAFE_0001;
    hold(3);
    chk("motion_led1", led[1], 1'b1);
    chk("motion_led0_quiet", led[0], 1'b0);
    chk("motion_led_hi", led[14:2], 13'b0);
    locations[0 +: W] = 32'h0BAD_0002;
    hold(3);
    chk("motion_led0", led[0], 1'b1);

    // Load and run accepted together while frames keep arriving.
    s0 = n_steps;
    btn_load = 1; btn_run = 1; frame_start = 1;
    hold(12);
    frame_start = 0;
    chk("load_wins_state", state, 2'd0);
    chk("load_wins_steps", n_steps - s0, 10);
    chk("load_clears_led", led, 16'h0000);
    btn_load = 0; btn_run = 0;
    hold(14);

    // Reset asserted in the second LOAD cycle.
    btn_load = 1;
    idx = 0;
    while (state != 2'd0 && idx < 40) begin tick(); idx++; end
    chk("reload_reached", state, 2'd0);
    btn_load = 0;
    tick();
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    chk("midload_erst", engine_rst_n, 1'b0);
    hold(2);
    rst_n = 1;
    check_load_window("midload");

    // Randomised traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 15) == 0) btn_run  = ~btn_run;
      if ($urandom_range(0, 15) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 23) == 0) btn_load = ~btn_load;
      frame_start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, SPR * DIM - 1);
        locations[idx*W +: W] = $urandom;
      end
      if ($urandom_range(0, 31) == 0) begin
        cfg_locations = {$urandom, $urandom, $urandom, $urandom};
        cfg_velos     = {$urandom, $urandom, $urandom, $urandom};
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
